// File: rtl/uart1_tx_serializer.sv
// uart1_tx_serializer: drains the UART1 TX FIFO and sends each byte on txd
// as 1 start bit, 8 data bits (LSB first), an optional parity bit and
// STOP_BITS stop bits.
//
// Optional feature macro: UART1_PARITY_EN (adds the PARITY state; PARITY_ODD
// selects the sense). Without it, frames are 8N1/8N2 and PARITY_ODD is unused.
//
// Ports:
//   clk            in   system clock
//   rst            in   synchronous reset, active-high
//   ena            in   transmit enable; gates fetching of new bytes only
//   tx_fifo_ren    out  FIFO read strobe, one cycle per byte
//   tx_fifo_rdata  in   FIFO read data, valid the cycle after tx_fifo_ren
//   tx_fifo_empty  in   FIFO empty flag
//   txd            out  serial output, idle high
//   busy           out  high from FETCH through the last stop-bit clock
//   byte_done      out  one-cycle pulse on the final clock of the last stop bit
module uart1_tx_serializer #(
    parameter int BAUD_DIV   = 434,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    output logic       tx_fifo_ren,
    input  logic [7:0] tx_fifo_rdata,
    input  logic       tx_fifo_empty,
    output logic       txd,
    output logic       busy,
    output logic       byte_done
);

    if (BAUD_DIV < 1 || BAUD_DIV > 65535 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart1_tx_serializer: illegal parameter value");
    end

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART1_PARITY_EN
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_cnt, bit_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        txd_nxt, ren_nxt, busy_nxt, done_nxt;
    logic        req, baud_end, last_stop;
`ifdef UART1_PARITY_EN
    logic        par, par_nxt;
`endif

    assign req       = ena && !tx_fifo_empty;
    assign baud_end  = cnt == BAUD_LAST;
    assign last_stop = state == STOP && baud_end && bit_cnt == STOP_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            txd         <= 1'b1;
            tx_fifo_ren <= 1'b0;
            busy        <= 1'b0;
            byte_done   <= 1'b0;
`ifdef UART1_PARITY_EN
            par         <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_cnt     <= bit_nxt;
            shift       <= shift_nxt;
            txd         <= txd_nxt;
            tx_fifo_ren <= ren_nxt;
            busy        <= busy_nxt;
            byte_done   <= done_nxt;
`ifdef UART1_PARITY_EN
            par         <= par_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = req ? FETCH : IDLE;
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = START;
            START:   state_nxt = baud_end ? DATA : START;
`ifdef UART1_PARITY_EN
            DATA:    state_nxt = (baud_end && bit_cnt == 3'd7) ? PARITY : DATA;
            PARITY:  state_nxt = baud_end ? STOP : PARITY;
`else
            DATA:    state_nxt = (baud_end && bit_cnt == 3'd7) ? STOP : DATA;
`endif
            STOP:    state_nxt = last_stop ? (req ? FETCH : IDLE) : STOP;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered, so each one is computed from the values the
    // state, counters and shift register take after this edge.
    always_comb begin
        cnt_nxt   = (state_nxt != state || baud_end || state == IDLE) ? '0 : cnt + 16'd1;
        bit_nxt   = (state_nxt != state) ? '0 :
                    (baud_end && (state == DATA || state == STOP)) ? bit_cnt + 3'd1 : bit_cnt;
        shift_nxt = (state == LOAD) ? tx_fifo_rdata :
                    (state == DATA && baud_end) ? shift >> 1 : shift;
`ifdef UART1_PARITY_EN
        par_nxt   = (state == LOAD) ? (^tx_fifo_rdata) ^ (PARITY_ODD != 0) : par;
        txd_nxt   = (state_nxt == START) ? 1'b0 :
                    (state_nxt == DATA) ? shift_nxt[0] :
                    (state_nxt == PARITY) ? par_nxt : 1'b1;
`else
        txd_nxt   = (state_nxt == START) ? 1'b0 :
                    (state_nxt == DATA) ? shift_nxt[0] : 1'b1;
`endif
        ren_nxt   = state_nxt == FETCH;
        busy_nxt  = state_nxt != IDLE;
        done_nxt  = state_nxt == STOP && cnt_nxt == BAUD_LAST && bit_nxt == STOP_LAST;
    end

endmodule

// File: tb/tb_uart1_tx_serializer.sv
// tb_uart1_tx_serializer: directed bench for uart1_tx_serializer with two
// instances (BAUD_DIV=4/1 stop bit and BAUD_DIV=1/2 stop bits) fed by queue FIFOs.
module tb_uart1_tx_serializer;

`ifdef UART1_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int SPACING = (10 + PB) * 4 + 2;

    logic clk = 1'b0, rst = 1'b1, ena0 = 1'b0, ena1 = 1'b0;
    logic ren0, ren1, empty0, empty1, txd0, txd1, busy0, busy1, done0, done1;
    logic [7:0] rdata0 = 8'h00, rdata1 = 8'h00;
    logic [7:0] q0[$], q1[$];
    int pushes0 = 0, reads0 = 0, pushes1 = 0, reads1 = 0, cyc = 0;
    int errors = 0, checks = 0;
    int ren_t[$];

    always #5 clk = ~clk;

    assign empty0 = pushes0 == reads0;
    assign empty1 = pushes1 == reads1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ren0) begin
            rdata0 <= q0.pop_front();
            reads0 <= reads0 + 1;
        end
        if (ren1) begin
            rdata1 <= q1.pop_front();
            reads1 <= reads1 + 1;
        end
    end

    always @(negedge clk) if (ren0) ren_t.push_back(cyc);

    uart1_tx_serializer #(.BAUD_DIV(4), .STOP_BITS(1), .PARITY_ODD(0)) u0 (
        .clk(clk), .rst(rst), .ena(ena0), .tx_fifo_ren(ren0), .tx_fifo_rdata(rdata0),
        .tx_fifo_empty(empty0), .txd(txd0), .busy(busy0), .byte_done(done0));

    uart1_tx_serializer #(.BAUD_DIV(1), .STOP_BITS(2), .PARITY_ODD(0)) u1 (
        .clk(clk), .rst(rst), .ena(ena1), .tx_fifo_ren(ren1), .tx_fifo_rdata(rdata1),
        .tx_fifo_empty(empty1), .txd(txd1), .busy(busy1), .byte_done(done1));

    task automatic push0(input logic [7:0] b);
        q0.push_back(b);
        pushes0++;
    endtask

    task automatic push1(input logic [7:0] b);
        q1.push_back(b);
        pushes1++;
    endtask

    // Counts negedges until txd is low; exp is the required count.
    task automatic wait_start(input bit sel, input int exp, input string nm);
        int k = 0;
        while ((sel ? txd1 : txd0) !== 1'b0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k !== exp) begin
            errors++;
            $display("FAIL %s start latency: got %0d clocks, expected %0d", nm, k, exp);
        end
    endtask

    // Called at the negedge of the first start-bit clock; returns at the
    // negedge after the last stop clock.
    task automatic expect_frame(input logic [7:0] b, input bit sel, input string nm);
        int baud = sel ? 1 : 4;
        int nb = 9 + PB + (sel ? 2 : 1);
        logic e, de;
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < baud; c++) begin
                e = (i == 0) ? 1'b0 : (i <= 8) ? b[i-1] : (PB == 1 && i == 9) ? ^b : 1'b1;
                checks++;
                if ((sel ? txd1 : txd0) !== e) begin
                    errors++;
                    $display("FAIL %s txd bit %0d clk %0d: got %b, expected %b", nm, i, c, sel ? txd1 : txd0, e);
                end
                checks++;
                if ((sel ? busy1 : busy0) !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy bit %0d clk %0d: got %b, expected 1", nm, i, c, sel ? busy1 : busy0);
                end
                if (i >= 9 + PB) begin
                    de = (i == nb - 1) && (c == baud - 1);
                    checks++;
                    if ((sel ? done1 : done0) !== de) begin
                        errors++;
                        $display("FAIL %s byte_done bit %0d clk %0d: got %b, expected %b", nm, i, c, sel ? done1 : done0, de);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({txd0, ren0, busy0, done0, txd1, ren1, busy1, done1} !== 8'b1000_1000) begin
            errors++;
            $display("FAIL reset outputs: got %b, expected 10001000",
                     {txd0, ren0, busy0, done0, txd1, ren1, busy1, done1});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        push0(8'h55);
        ena0 = 1'b1;
        @(negedge clk);
        checks++;
        if ({ren0, busy0, txd0} !== 3'b111) begin
            errors++;
            $display("FAIL single fetch {ren,busy,txd}: got %b, expected 111", {ren0, busy0, txd0});
        end
        @(negedge clk);
        checks++;
        if ({ren0, busy0, txd0} !== 3'b011) begin
            errors++;
            $display("FAIL single load {ren,busy,txd}: got %b, expected 011", {ren0, busy0, txd0});
        end
        @(negedge clk);
        expect_frame(8'h55, 1'b0, "single");
        checks++;
        if ({busy0, txd0, done0, ren0} !== 4'b0100 || reads0 !== 1) begin
            errors++;
            $display("FAIL single end {busy,txd,done,ren}=%b reads=%0d, expected 0100 reads=1",
                     {busy0, txd0, done0, ren0}, reads0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4] = '{8'hFF, 8'h7F, 8'hFF, 8'h7F};
        int n0 = ren_t.size();
        foreach (bytes[i]) push0(bytes[i]);
        for (int i = 0; i < 4; i++) begin
            wait_start(1'b0, i == 0 ? 3 : 2, "b2b");
            expect_frame(bytes[i], 1'b0, "b2b");
        end
        checks++;
        if (ren_t.size() - n0 !== 4) begin
            errors++;
            $display("FAIL b2b ren pulses: got %0d, expected 4", ren_t.size() - n0);
        end
        for (int i = n0 + 1; i < ren_t.size(); i++) begin
            checks++;
            if (ren_t[i] - ren_t[i-1] !== SPACING) begin
                errors++;
                $display("FAIL b2b ren spacing %0d: got %0d, expected %0d", i - n0, ren_t[i] - ren_t[i-1], SPACING);
            end
        end
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b busy after drain: got %b, expected 0", busy0);
        end
    endtask

    task automatic test_ena_drop();
        int r0 = reads0;
        push0(8'h12);
        push0(8'hA5);
        push0(8'h3C);
        wait_start(1'b0, 3, "ena_drop");
        fork
            expect_frame(8'h12, 1'b0, "ena_drop");
            begin
                repeat (6) @(negedge clk);
                ena0 = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        checks++;
        if (busy0 !== 1'b0 || reads0 - r0 !== 1 || pushes0 - reads0 !== 2) begin
            errors++;
            $display("FAIL ena_drop busy=%b reads=%0d level=%0d, expected busy=0 reads=1 level=2",
                     busy0, reads0 - r0, pushes0 - reads0);
        end
    endtask

    task automatic test_reset_mid_frame();
        int r0 = reads0;
        ena0 = 1'b1;
        wait_start(1'b0, 3, "rst_mid");
        repeat (17) @(negedge clk);
        checks++;
        if ({txd0, busy0} !== 2'b01) begin
            errors++;
            $display("FAIL rst_mid bit3 of A5 {txd,busy}: got %b, expected 01", {txd0, busy0});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({txd0, busy0, ren0} !== 3'b100) begin
            errors++;
            $display("FAIL rst_mid after reset {txd,busy,ren}: got %b, expected 100", {txd0, busy0, ren0});
        end
        rst = 1'b0;
        wait_start(1'b0, 3, "rst_mid");
        expect_frame(8'h3C, 1'b0, "rst_mid");
        checks++;
        if (reads0 - r0 !== 2 || pushes0 !== reads0) begin
            errors++;
            $display("FAIL rst_mid reads=%0d level=%0d, expected reads=2 level=0", reads0 - r0, pushes0 - reads0);
        end
    endtask

`ifdef UART1_PARITY_EN
    task automatic test_parity();
        push0(8'h07);
        wait_start(1'b0, 3, "parity");
        expect_frame(8'h07, 1'b0, "parity");
    endtask
`endif

    task automatic test_min_baud();
        push1(8'h00);
        ena1 = 1'b1;
        wait_start(1'b1, 3, "min_baud");
        expect_frame(8'h00, 1'b1, "min_baud");
        checks++;
        if ({busy1, txd1} !== 2'b01 || reads1 !== 1) begin
            errors++;
            $display("FAIL min_baud end {busy,txd}=%b reads=%0d, expected 01 reads=1", {busy1, txd1}, reads1);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_ena_drop();
        test_reset_mid_frame();
`ifdef UART1_PARITY_EN
        test_parity();
`endif
        test_min_baud();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
